// File: rtl/guess_controller.sv
// ----------------------------------------------------------------------------
// guess_controller
//
// Sequences one Mastermind round between the stabilized key pulses and the
// display/feedback logic. The player edits a guess digit by digit (inc/next).
// Each submitted guess (enter) is scored against the secret that was latched
// at new-game time, and the attempts are counted until a win or a loss.
//
// Scoring is split over MAX_VAL+1 cycles. The exact count is taken at enter.
// CHECK then visits each value v once and accumulates
// min(count of v in guess, count of v in secret). That total is every value
// match. The partial count is that total minus the exact count.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high; clears all registers
//   newgame_p    in   pulse: start a new game (highest priority, any state)
//   enter_p      in   pulse: submit current guess (ENTRY only)
//   next_p       in   pulse: advance cursor (ENTRY only)
//   inc_p        in   pulse: increment digit under cursor (ENTRY only)
//   secret       in   code to break, position i at [i*VAL_W +: VAL_W]
//   guess        out  current guess, same packing as secret
//   cursor       out  position being edited
//   exact        out  right value, right place (last scored guess)
//   partial      out  right value, wrong place (last scored guess)
//   tries        out  guesses scored this game
//   score_valid  out  one-cycle pulse when exact/partial/tries update
//   busy         out  high while scoring (CHECK)
//   win          out  level, high in WIN
//   lose         out  level, high in LOSE
// ----------------------------------------------------------------------------
module guess_controller #(
   parameter int NUM_POS   = 4,
   parameter int VAL_W     = 3,
   parameter int MAX_VAL   = 5,
   parameter int MAX_TRIES = 10,
   localparam int CODE_W   = NUM_POS * VAL_W,
   localparam int CUR_W    = (NUM_POS > 1) ? $clog2(NUM_POS) : 1,
   localparam int CNT_W    = $clog2(NUM_POS + 1),
   localparam int TRY_W    = $clog2(MAX_TRIES + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              newgame_p,
   input  logic              enter_p,
   input  logic              next_p,
   input  logic              inc_p,
   input  logic [CODE_W-1:0] secret,
   output logic [CODE_W-1:0] guess,
   output logic [CUR_W-1:0]  cursor,
   output logic [CNT_W-1:0]  exact,
   output logic [CNT_W-1:0]  partial,
   output logic [TRY_W-1:0]  tries,
   output logic              score_valid,
   output logic              busy,
   output logic              win,
   output logic              lose
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_CHECK,
      S_WIN,
      S_LOSE
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic [CODE_W-1:0]   r_secret;
   logic [CODE_W-1:0]   r_guess;
   logic [CUR_W-1:0]    r_cursor;
   logic [CNT_W-1:0]    r_exact;
   logic [CNT_W-1:0]    r_partial;
   logic [TRY_W-1:0]    r_tries;
   logic                r_score_valid;
   logic [CNT_W-1:0]    r_exact_hold;   // exact count captured at enter
   logic [CNT_W-1:0]    r_acc;          // running sum of per-value minima
   logic [VAL_W-1:0]    r_v;            // value being tallied in CHECK

   // Decoded actions after priority arbitration
   logic                w_do_newgame;
   logic                w_do_enter;
   logic                w_do_next;
   logic                w_do_inc;
   logic                w_finish;

   logic [CNT_W-1:0]    w_guess_cnt;
   logic [CNT_W-1:0]    w_secret_cnt;
   logic [CNT_W-1:0]    w_acc_next;
   logic [CNT_W-1:0]    w_exact_now;
   logic [TRY_W-1:0]    w_tries_inc;
   logic [VAL_W-1:0]    w_digit;
   logic [VAL_W-1:0]    w_digit_inc;
   logic [CUR_W-1:0]    w_cursor_inc;

   // Number of positions of code holding value val
   function automatic logic [CNT_W-1:0] f_count(input logic [CODE_W-1:0] code,
                                                input logic [VAL_W-1:0]  val);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_POS; i++) begin
         if (code[i*VAL_W +: VAL_W] == val) n = n + CNT_W'(1);
      end
      return n;
   endfunction

   // Number of positions where both codes agree (any value, even above MAX_VAL)
   function automatic logic [CNT_W-1:0] f_exact(input logic [CODE_W-1:0] a,
                                                input logic [CODE_W-1:0] b);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_POS; i++) begin
         if (a[i*VAL_W +: VAL_W] == b[i*VAL_W +: VAL_W]) n = n + CNT_W'(1);
      end
      return n;
   endfunction

   // ------------------------------------------------------------------
   // Datapath helpers
   // ------------------------------------------------------------------
   always_comb begin
      w_guess_cnt  = f_count(r_guess, r_v);
      w_secret_cnt = f_count(r_secret, r_v);
      // v only sweeps 0..MAX_VAL, so out-of-range secret digits never add here
      w_acc_next   = r_acc + ((w_guess_cnt < w_secret_cnt) ? w_guess_cnt : w_secret_cnt);
      w_exact_now  = f_exact(r_guess, r_secret);
      w_tries_inc  = r_tries + TRY_W'(1);
      w_digit      = r_guess[int'(r_cursor)*VAL_W +: VAL_W];
      // ">=" also folds any out-of-range stored digit back to 0
      w_digit_inc  = (w_digit >= VAL_W'(MAX_VAL)) ? '0 : w_digit + VAL_W'(1);
      w_cursor_inc = (r_cursor == CUR_W'(NUM_POS - 1)) ? '0 : r_cursor + CUR_W'(1);
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every register sees the
   // pre-edge values of the others, whatever order the blocks run in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // ------------------------------------------------------------------
   // FSM: next state and action decode
   // ------------------------------------------------------------------
   // NOTE: every signal is given a default before the case. If any path left
   // one unassigned, a latch would be inferred.
   always_comb begin
      w_next_state = r_state;
      w_do_newgame = 1'b0;
      w_do_enter   = 1'b0;
      w_do_next    = 1'b0;
      w_do_inc     = 1'b0;
      w_finish     = 1'b0;

      if (newgame_p) begin
         // Accepted in every state. This also aborts a scoring in progress.
         w_do_newgame = 1'b1;
         w_next_state = S_ENTRY;
      end else begin
         case (r_state)
            S_ENTRY: begin
               // Priority enter > next > inc; losers are dropped
               if (enter_p) begin
                  w_do_enter   = 1'b1;
                  w_next_state = S_CHECK;
               end else if (next_p) begin
                  w_do_next    = 1'b1;
               end else if (inc_p) begin
                  w_do_inc     = 1'b1;
               end
            end
            S_CHECK: begin
               if (r_v == VAL_W'(MAX_VAL)) begin
                  w_finish = 1'b1;
                  if (r_exact_hold == CNT_W'(NUM_POS))
                     w_next_state = S_WIN;
                  else if (w_tries_inc == TRY_W'(MAX_TRIES))
                     w_next_state = S_LOSE;
                  else
                     w_next_state = S_ENTRY;
               end
            end
            default: w_next_state = r_state;   // IDLE, WIN, LOSE wait for newgame
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_secret      <= '0;
         r_guess       <= '0;
         r_cursor      <= '0;
         r_exact       <= '0;
         r_partial     <= '0;
         r_tries       <= '0;
         r_score_valid <= 1'b0;
         r_exact_hold  <= '0;
         r_acc         <= '0;
         r_v           <= '0;
      end else begin
         r_score_valid <= w_finish;

         if (w_do_newgame) begin
            r_secret     <= secret;
            r_guess      <= '0;
            r_cursor     <= '0;
            r_exact      <= '0;
            r_partial    <= '0;
            r_tries      <= '0;
            r_exact_hold <= '0;
            r_acc        <= '0;
            r_v          <= '0;
         end else if (w_do_enter) begin
            r_exact_hold <= w_exact_now;
            r_acc        <= '0;
            r_v          <= '0;
         end else if (w_do_next) begin
            r_cursor     <= w_cursor_inc;
         end else if (w_do_inc) begin
            r_guess[int'(r_cursor)*VAL_W +: VAL_W] <= w_digit_inc;
         end else if (r_state == S_CHECK) begin
            r_acc <= w_acc_next;
            r_v   <= r_v + VAL_W'(1);
            if (w_finish) begin
               r_exact   <= r_exact_hold;
               r_partial <= w_acc_next - r_exact_hold;
               r_tries   <= w_tries_inc;
            end
         end
      end
   end

   assign guess       = r_guess;
   assign cursor      = r_cursor;
   assign exact       = r_exact;
   assign partial     = r_partial;
   assign tries       = r_tries;
   assign score_valid = r_score_valid;
   assign busy        = (r_state == S_CHECK);
   assign win         = (r_state == S_WIN);
   assign lose        = (r_state == S_LOSE);

endmodule

// File: tb/tb_guess_controller.sv
// ----------------------------------------------------------------------------
// tb_guess_controller
//
// Directed bench for guess_controller with the default parameters. Inputs are
// driven and outputs are sampled on the falling clock edge. Expected values
// are worked out by hand from the game rules.
// ----------------------------------------------------------------------------
module tb_guess_controller;

   localparam int NUM_POS = 4;
   localparam int VAL_W   = 3;
   localparam int CODE_W  = NUM_POS * VAL_W;

   logic              clk;
   logic              reset;
   logic              newgame_p;
   logic              enter_p;
   logic              next_p;
   logic              inc_p;
   logic [CODE_W-1:0] secret;
   logic [CODE_W-1:0] guess;
   logic [1:0]        cursor;
   logic [2:0]        exact;
   logic [2:0]        partial;
   logic [3:0]        tries;
   logic              score_valid;
   logic              busy;
   logic              win;
   logic              lose;

   int n_vec = 0;
   int n_err = 0;

   guess_controller dut (
      .clk         (clk),
      .reset       (reset),
      .newgame_p   (newgame_p),
      .enter_p     (enter_p),
      .next_p      (next_p),
      .inc_p       (inc_p),
      .secret      (secret),
      .guess       (guess),
      .cursor      (cursor),
      .exact       (exact),
      .partial     (partial),
      .tries       (tries),
      .score_valid (score_valid),
      .busy        (busy),
      .win         (win),
      .lose        (lose)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   // One-cycle pulse on any combination of keys, sampled by a single rising edge.
   // Returns at the falling edge after that edge, so the outputs can be read.
   task automatic apply(input logic ng, input logic en, input logic nx, input logic ic);
      @(negedge clk);
      newgame_p = ng;
      enter_p   = en;
      next_p    = nx;
      inc_p     = ic;
      @(negedge clk);
      newgame_p = 1'b0;
      enter_p   = 1'b0;
      next_p    = 1'b0;
      inc_p     = 1'b0;
   endtask

   task automatic new_game(input logic [CODE_W-1:0] s);
      secret = s;
      apply(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Enter a code from a freshly cleared guess. The cursor ends back at 0.
   task automatic set_guess(input logic [CODE_W-1:0] code);
      logic [VAL_W-1:0] d;
      for (int p = 0; p < NUM_POS; p++) begin
         d = code[p*VAL_W +: VAL_W];
         for (int k = 0; k < int'(d); k++) apply(1'b0, 1'b0, 1'b0, 1'b1);
         apply(1'b0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   // Submit and wait (bounded) for the score. The pulse must arrive 6 edges
   // after enter, and busy must stay high until then.
   task automatic score(input string tag, input int ex, input int pa, input int tr);
      int  k;
      int  busy_low;
      bit  seen;
      apply(1'b0, 1'b1, 1'b0, 1'b0);
      check({tag, " busy_after_enter"}, busy, 1);
      k = 0; busy_low = 0; seen = 0;
      while (!seen && k < 20) begin
         @(negedge clk);
         k++;
         if (score_valid) seen = 1;
         else if (!busy)  busy_low++;
      end
      check({tag, " latency"}, k, 6);
      check({tag, " busy_gap"}, busy_low, 0);
      check({tag, " busy_at_valid"}, busy, 0);
      check({tag, " exact"}, exact, ex);
      check({tag, " partial"}, partial, pa);
      check({tag, " tries"}, tries, tr);
      @(negedge clk);
      check({tag, " valid_one_cycle"}, score_valid, 0);
   endtask

   // Bounded watch for an unwanted score pulse
   task automatic no_score(input string tag, input int cycles);
      int hits;
      hits = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (score_valid) hits++;
      end
      check({tag, " no_score_valid"}, hits, 0);
   endtask

   // Secret positions 3..0 = 1,2,3,4
   localparam logic [CODE_W-1:0] SEC_A  = {3'd1, 3'd2, 3'd3, 3'd4};
   localparam logic [CODE_W-1:0] G_REV  = {3'd4, 3'd3, 3'd2, 3'd1};
   localparam logic [CODE_W-1:0] G_SWAP = {3'd1, 3'd2, 3'd4, 3'd3};
   localparam logic [CODE_W-1:0] SEC_D  = {3'd1, 3'd1, 3'd2, 3'd2};
   localparam logic [CODE_W-1:0] G_D    = {3'd1, 3'd2, 3'd2, 3'd2};

   initial begin
      reset = 1'b1;
      newgame_p = 1'b0; enter_p = 1'b0; next_p = 1'b0; inc_p = 1'b0;
      secret = SEC_A;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // ---- reset state ----
      check("rst guess", guess, 0);
      check("rst cursor", cursor, 0);
      check("rst scores", {exact, partial, tries}, 0);
      check("rst flags", {score_valid, busy, win, lose}, 0);

      // ---- IDLE ignores edit/enter keys ----
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      apply(1'b0, 1'b0, 1'b1, 1'b0);
      apply(1'b0, 1'b1, 1'b0, 1'b0);
      check("idle busy", busy, 0);
      check("idle guess", guess, 0);
      check("idle cursor", cursor, 0);
      no_score("idle", 8);
      check("idle flags", {win, lose, tries}, 0);

      // ---- edit and wrap ----
      new_game(SEC_A);
      check("ng guess", guess, 0);
      check("ng cursor", cursor, 0);
      for (int i = 0; i < 7; i++) apply(1'b0, 1'b0, 1'b0, 1'b1);
      check("inc wrap", guess, 12'h001);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b1, 1'b0);
      check("cursor 3", cursor, 3);
      apply(1'b0, 1'b0, 1'b1, 1'b0);
      check("cursor wrap", cursor, 0);
      apply(1'b0, 1'b0, 1'b1, 1'b1);
      check("next beats inc cursor", cursor, 1);
      check("next beats inc guess", guess, 12'h001);
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      check("inc at pos1", guess, 12'h009);

      // ---- scoring ----
      new_game(SEC_A);
      set_guess(G_REV);
      check("set rev", guess, G_REV);
      score("rev", 0, 4, 1);
      check("rev flags", {win, lose}, 0);

      new_game(SEC_A);
      set_guess(G_SWAP);
      score("swap", 2, 2, 1);

      new_game(SEC_D);
      set_guess(G_D);
      score("dup", 3, 0, 1);

      // ---- win, then keys ignored ----
      new_game(SEC_A);
      set_guess(SEC_A);
      score("win", 4, 0, 1);
      check("win level", {win, lose}, 2'b10);
      apply(1'b0, 1'b1, 1'b0, 1'b0);
      check("win enter ignored", busy, 0);
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      check("win inc ignored", guess, SEC_A);
      no_score("win", 8);
      check("win hold", {win, tries}, {1'b1, 4'd1});

      // ---- lose after 10 wrong guesses ----
      new_game(SEC_A);
      set_guess(G_REV);
      for (int i = 0; i < 10; i++) begin
         score("lose", 0, 4, i + 1);
         check("lose level", lose, (i == 9) ? 1 : 0);
      end
      check("lose win low", win, 0);
      apply(1'b0, 1'b1, 1'b0, 1'b0);
      check("lose enter ignored", busy, 0);
      check("lose tries", tries, 10);

      // ---- newgame aborts CHECK ----
      new_game(SEC_A);
      set_guess(G_SWAP);
      score("pre_abort", 2, 2, 1);
      apply(1'b0, 1'b1, 1'b0, 1'b0);
      check("abort busy", busy, 1);
      @(negedge clk);
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      check("abort busy low", busy, 0);
      check("abort tries", tries, 0);
      check("abort scores", {exact, partial}, 0);
      no_score("abort", 10);
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      check("abort in entry", guess, 12'h001);

      // ---- newgame + enter together ----
      apply(1'b1, 1'b1, 1'b0, 1'b0);
      check("ng+enter busy", busy, 0);
      check("ng+enter guess", guess, 0);
      no_score("ng+enter", 10);
      check("ng+enter tries", tries, 0);

      // ---- async reset mid-CHECK ----
      new_game(SEC_A);
      set_guess(G_SWAP);
      score("pre_rst", 2, 2, 1);
      apply(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst busy", busy, 0);
      check("arst guess", guess, 0);
      check("arst scores", {exact, partial, tries}, 0);
      @(negedge clk);
      reset = 1'b0;
      no_score("arst", 8);
      apply(1'b0, 1'b0, 1'b0, 1'b1);
      check("arst idle", {guess, win, lose}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
